// File: rtl/fdm_sequencer_pkg.sv
// Shared definitions for the finite-difference sequencer: state encoding,
// byte ordering of the transmitted array and word/byte geometry helpers.
package fdm_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_TX   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Each element goes out most-significant byte first.
    localparam bit MSB_BYTE_FIRST = 1'b1;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/fdm_byte_serializer.sv
// Streams a captured NU*WIDTH array as bytes over a valid/ready handshake,
// element 0 first, signalling the cycle its final byte is accepted.
module fdm_byte_serializer
    import fdm_sequencer_pkg::*;
#(
    parameter int NU    = 10,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [NU*WIDTH-1:0]   snapshot,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  last_accept
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int NB  = NU * BPW;
    localparam int BCW = $clog2(NB + 1);

    logic [NB*8-1:0] ordered;
    logic [NB*8-1:0] pending;
    logic [BCW-1:0]  byte_idx;
    logic            accept;

    // Rearrange the snapshot so transmission order is simply lowest byte first.
    always_comb begin
        ordered = '0;
        for (int e = 0; e < NU; e++) begin
            for (int b = 0; b < BPW; b++) begin
                ordered[(e*BPW + b)*8 +: 8] =
                    snapshot[e*WIDTH + (MSB_BYTE_FIRST ? (BPW - 1 - b) : b)*8 +: 8];
            end
        end
    end

    assign accept      = tx_valid && tx_ready;
    assign last_accept = accept && (byte_idx == BCW'(NB - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            pending  <= '0;
            byte_idx <= '0;
        end else if (load) begin
            tx_data  <= ordered[7:0];
            pending  <= ordered >> 8;
            tx_valid <= 1'b1;
            byte_idx <= '0;
        end else if (accept) begin
            if (last_accept) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data  <= pending[7:0];
                pending  <= pending >> 8;
                byte_idx <= byte_idx + BCW'(1);
            end
        end
    end

endmodule

// File: rtl/fdm_sequencer.sv
// Jacobi sweep controller: owns the solution array, runs up to niter sweeps
// with early exit on convergence, then hands the result to the byte serializer.
module fdm_sequencer
    import fdm_sequencer_pkg::*;
#(
    parameter int NU    = 10,
    parameter int WIDTH = 32,
    parameter int CNTW  = 32
) (
    input  logic                  clk40mhz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNTW-1:0]       niter,
    input  logic [WIDTH-1:0]      tol,
    output logic [NU*WIDTH-1:0]   u_cur,
    input  logic [NU*WIDTH-1:0]   u_next,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [CNTW-1:0]       iter_cnt
);

    state_t                state;
    state_t                state_next;
    logic [CNTW-1:0]       niter_q;
    logic [WIDTH-1:0]      tol_q;
    logic                  conv;
    logic                  last_sweep;
    logic                  accept_start;
    logic                  ser_load;
    logic [NU*WIDTH-1:0]   ser_snapshot;
    logic                  last_accept;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag;

    // One extra bit keeps the element-wise difference free of overflow.
    always_comb begin
        conv = 1'b1;
        diff = '0;
        mag  = '0;
        for (int k = 0; k < NU; k++) begin
            diff = $signed({u_next[k*WIDTH + WIDTH - 1], u_next[k*WIDTH +: WIDTH]})
                 - $signed({u_cur[k*WIDTH + WIDTH - 1], u_cur[k*WIDTH +: WIDTH]});
            mag  = diff[WIDTH] ? (WIDTH+1)'(-diff) : diff;
            if (mag > {1'b0, tol_q}) begin
                conv = 1'b0;
            end
        end
    end

    assign last_sweep   = (iter_cnt + CNTW'(1)) == niter_q;
    assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy         = (state == ST_CALC) || (state == ST_TX);
    assign done         = (state == ST_DONE);

    always_ff @(posedge clk40mhz or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The serializer captures the value being committed on the same edge as TX entry.
    always_comb begin
        state_next   = state;
        ser_load     = 1'b0;
        ser_snapshot = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (niter == '0) begin
                        state_next = ST_TX;
                        ser_load   = 1'b1;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (conv || last_sweep) begin
                    state_next   = ST_TX;
                    ser_load     = 1'b1;
                    ser_snapshot = u_next;
                end
            end
            ST_TX: begin
                if (last_accept) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk40mhz or negedge reset) begin
        if (!reset) begin
            u_cur     <= '0;
            iter_cnt  <= '0;
            converged <= 1'b0;
            niter_q   <= '0;
            tol_q     <= '0;
        end else if (accept_start) begin
            niter_q   <= niter;
            tol_q     <= tol;
            u_cur     <= '0;
            iter_cnt  <= '0;
            converged <= 1'b0;
        end else if (state == ST_CALC) begin
            u_cur    <= u_next;
            iter_cnt <= iter_cnt + CNTW'(1);
            if (conv) begin
                converged <= 1'b1;
            end
        end
    end

    fdm_byte_serializer #(
        .NU    (NU),
        .WIDTH (WIDTH)
    ) u_serializer (
        .clk         (clk40mhz),
        .reset       (reset),
        .load        (ser_load),
        .snapshot    (ser_snapshot),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .last_accept (last_accept)
    );

endmodule

// File: tb/tb_fdm_sequencer.sv
// Self-checking bench for fdm_sequencer with a small jacobi stub and an
// array-level reference model of the sweep / convergence / byte stream rules.
module tb_fdm_sequencer;

    localparam int NU    = 4;
    localparam int WIDTH = 16;
    localparam int CNTW  = 32;
    localparam int BPW   = WIDTH / 8;
    localparam int NB    = NU * BPW;

    logic                clk40mhz = 1'b0;
    logic                reset    = 1'b1;
    logic                start    = 1'b0;
    logic                tx_ready = 1'b0;
    logic [CNTW-1:0]     niter    = '0;
    logic [WIDTH-1:0]    tol      = '0;
    logic [NU*WIDTH-1:0] u_cur;
    logic [NU*WIDTH-1:0] u_next;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                busy;
    logic                done;
    logic                converged;
    logic [CNTW-1:0]     iter_cnt;

    int      checks = 0;
    int      errors = 0;
    int      stub_mode = 0;
    shortint target[NU];

    typedef struct {
        int          mode;
        int          n;
        int          t;
        int          rdy;
        int          it;
        int          cv;
        bit          poke;
        logic [63:0] u;
    } vec_t;

    vec_t vecs[7];

    fdm_sequencer #(
        .NU    (NU),
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk40mhz  (clk40mhz),
        .reset     (reset),
        .start     (start),
        .niter     (niter),
        .tol       (tol),
        .u_cur     (u_cur),
        .u_next    (u_next),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .iter_cnt  (iter_cnt)
    );

    always #10 clk40mhz = ~clk40mhz;

    // Stub modes: 0 adds one, 1 is a fixed point, 3 moves halfway to a target.
    function automatic shortint stub_step(input int mode, input shortint tgt, input shortint u);
        case (mode)
            0:       return shortint'(int'(u) + 1);
            1:       return u;
            default: return shortint'(int'(u) + (int'(tgt) - int'(u)) / 2);
        endcase
    endfunction

    always_comb begin
        u_next = '0;
        for (int k = 0; k < NU; k++) begin
            u_next[k*WIDTH +: WIDTH] = stub_step(stub_mode, target[k], shortint'(u_cur[k*WIDTH +: WIDTH]));
        end
    end

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", tag, what, act, exp);
        end
    endtask

    // Reference: iterate on plain integer arrays until tolerance or sweep limit.
    task automatic model_run(input int mode, input int n, input int t,
                             output int it, output int cv, output logic [63:0] fin);
        shortint u[NU];
        shortint nx[NU];
        bit      c;
        int      d;
        for (int k = 0; k < NU; k++) u[k] = 0;
        it = 0;
        cv = 0;
        while (it < n) begin
            c = 1'b1;
            for (int k = 0; k < NU; k++) begin
                nx[k] = stub_step(mode, target[k], u[k]);
                d = int'(nx[k]) - int'(u[k]);
                if (d < 0) d = -d;
                if (d > t) c = 1'b0;
            end
            u = nx;
            it++;
            if (c) begin
                cv = 1;
                break;
            end
        end
        fin = '0;
        for (int k = 0; k < NU; k++) fin[k*WIDTH +: WIDTH] = u[k];
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] fin, input int j);
        logic [WIDTH-1:0] word;
        int               e;
        int               b;
        e    = j / BPW;
        b    = j % BPW;
        word = fin[e*WIDTH +: WIDTH];
        return 8'(word >> (8 * (BPW - 1 - b)));
    endfunction

    task automatic reset_checks(input string tag);
        check(tag, "u_cur",     u_cur,     0);
        check(tag, "iter_cnt",  iter_cnt,  0);
        check(tag, "tx_valid",  tx_valid,  0);
        check(tag, "tx_data",   tx_data,   0);
        check(tag, "busy",      busy,      0);
        check(tag, "done",      done,      0);
        check(tag, "converged", converged, 0);
    endtask

    task automatic run_case(input string tag, input int mode, input int n, input int t, input int rdy,
                            input int exp_it, input int exp_cv, input bit poke, input logic [63:0] exp_u);
        int calc;
        int idx;
        int cyc;
        bit r;
        stub_mode = mode;
        niter     = CNTW'(n);
        tol       = WIDTH'(t);
        start     = 1'b1;
        @(negedge clk40mhz);
        start = 1'b0;
        niter = '1;
        tol   = '0;
        check(tag, "busy_after_start", busy, 1);
        calc = 0;
        while (busy && !tx_valid && calc < 200) begin
            if (poke && calc == 1) start = 1'b1;
            @(negedge clk40mhz);
            start = 1'b0;
            calc++;
        end
        check(tag, "calc_cycles", calc, exp_it);
        check(tag, "tx_valid_after_calc", tx_valid, 1);
        idx = 0;
        cyc = 0;
        while (!done && cyc < 400) begin
            r = 1'b0;
            if (tx_valid) begin
                if (idx < NB) check(tag, "tx_byte", tx_data, exp_byte(exp_u, idx));
                else          check(tag, "extra_byte", idx, NB - 1);
                case (rdy)
                    0:       r = 1'b1;
                    1:       r = (cyc % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
            end else begin
                check(tag, "tx_valid_in_tx", tx_valid, 1);
            end
            tx_ready = r;
            if (poke && cyc == 2) start = 1'b1;
            @(negedge clk40mhz);
            start = 1'b0;
            if (r) idx++;
            cyc++;
        end
        tx_ready = 1'b0;
        check(tag, "byte_count", idx, NB);
        if (rdy == 0) check(tag, "tx_cycles", cyc, NB);
        check(tag, "done",      done,      1);
        check(tag, "busy",      busy,      0);
        check(tag, "tx_valid",  tx_valid,  0);
        check(tag, "iter_cnt",  iter_cnt,  exp_it);
        check(tag, "converged", converged, exp_cv);
        check(tag, "u_cur",     u_cur,     exp_u);
    endtask

    initial begin
        int          it;
        int          cv;
        int          m;
        int          k;
        logic [63:0] fin;

        for (int i = 0; i < NU; i++) target[i] = 0;
        #5 reset = 1'b0;
        repeat (2) @(negedge clk40mhz);
        reset_checks("reset");
        reset = 1'b1;
        @(negedge clk40mhz);

        vecs[0] = '{0,   3, 0, 0, 3, 0, 1'b0, 64'h0003_0003_0003_0003};
        vecs[1] = '{0,   0, 0, 0, 0, 0, 1'b0, 64'h0000_0000_0000_0000};
        vecs[2] = '{1, 100, 0, 0, 1, 1, 1'b0, 64'h0000_0000_0000_0000};
        vecs[3] = '{0,   3, 0, 1, 3, 0, 1'b0, 64'h0003_0003_0003_0003};
        vecs[4] = '{0,   3, 0, 0, 3, 0, 1'b1, 64'h0003_0003_0003_0003};
        vecs[5] = '{0,   5, 1, 0, 1, 1, 1'b0, 64'h0001_0001_0001_0001};
        vecs[6] = '{1,   1, 0, 2, 1, 1, 1'b0, 64'h0000_0000_0000_0000};
        for (int i = 0; i < 7; i++) begin
            run_case($sformatf("vec%0d", i), vecs[i].mode, vecs[i].n, vecs[i].t, vecs[i].rdy,
                     vecs[i].it, vecs[i].cv, vecs[i].poke, vecs[i].u);
        end

        // Reset while byte 3 is being offered, then a clean run from scratch.
        stub_mode = 0;
        niter     = 3;
        tol       = 0;
        start     = 1'b1;
        @(negedge clk40mhz);
        start = 1'b0;
        k = 0;
        while (!tx_valid && k < 50) begin
            @(negedge clk40mhz);
            k++;
        end
        check("abort", "reach_tx", tx_valid, 1);
        tx_ready = 1'b1;
        repeat (3) @(negedge clk40mhz);
        tx_ready = 1'b0;
        check("abort", "byte3", tx_data, 8'h03);
        #2 reset = 1'b0;
        #1 reset_checks("abort");
        @(negedge clk40mhz);
        reset = 1'b1;
        @(negedge clk40mhz);
        run_case("after_reset", 0, 3, 0, 0, 3, 0, 1'b0, 64'h0003_0003_0003_0003);

        for (int i = 0; i < 20; i++) begin
            m = $urandom_range(0, 2);
            if (m == 2) m = 3;
            for (int j = 0; j < NU; j++) target[j] = shortint'(int'($urandom_range(0, 2000)) - 1000);
            model_run(m, $urandom_range(0, 15), 0, it, cv, fin);
            begin
                int n;
                int t;
                n = $urandom_range(0, 15);
                t = $urandom_range(0, 300);
                model_run(m, n, t, it, cv, fin);
                run_case($sformatf("rand%0d", i), m, n, t, $urandom_range(0, 2), it, cv,
                         1'($urandom_range(0, 1)), fin);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
